// File: rtl/w2_stream_loader.sv
// Load sequencer for the two-layer classifier: streams the pixel vector and
// layer-2 weight rows into SRAM and gates the compute controller's reset.
module w2_stream_loader #(
  parameter int DW      = 16,
  parameter int ROW_LEN = 16,
  parameter int AW      = 4,
  parameter int N_ROWS  = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          go,
  input  logic          pix_valid,
  output logic          pix_ready,
  input  logic          host_valid,
  input  logic [DW-1:0] host_data,
  output logic          host_ready,
  output logic          in_we,
  output logic          w2_we,
  output logic [AW-1:0] w2_addr,
  output logic [DW-1:0] w2_data,
  input  logic          next_row,
  input  logic          core_done,
  output logic          core_reset,
  output logic          busy,
  output logic          done,
  output logic          err_underrun
);

  localparam int RW = $clog2(N_ROWS + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_PIX,
    LOAD_ROW0,
    RUN,
    REFILL,
    FINISH
  } state_t;

  state_t        state_reg, state_next;
  logic [AW-1:0] word_cnt_reg, word_cnt_next;
  logic [RW-1:0] rows_loaded_reg, rows_loaded_next;
  logic [RW-1:0] rows_inc;
  logic          err_reg, err_next;
  logic          core_reset_reg, core_reset_next;
  logic          word_accept;
  logic          last_word;
  logic          rows_full;

  assign word_accept = host_valid & host_ready;
  assign last_word   = (word_cnt_reg == AW'(ROW_LEN - 1));
  assign rows_inc    = rows_loaded_reg + RW'(1);
  assign rows_full   = (rows_loaded_reg == RW'(N_ROWS));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      word_cnt_reg    <= '0;
      rows_loaded_reg <= '0;
      err_reg         <= 1'b0;
      core_reset_reg  <= 1'b1;
    end else begin
      state_reg       <= state_next;
      word_cnt_reg    <= word_cnt_next;
      rows_loaded_reg <= rows_loaded_next;
      err_reg         <= err_next;
      core_reset_reg  <= core_reset_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    word_cnt_next    = word_cnt_reg;
    rows_loaded_next = rows_loaded_reg;
    err_next         = err_reg;
    pix_ready        = 1'b0;
    host_ready       = 1'b0;

    case (state_reg)
      IDLE: begin
        if (go) begin
          state_next       = LOAD_PIX;
          err_next         = 1'b0;
          rows_loaded_next = '0;
          word_cnt_next    = '0;
        end
      end

      LOAD_PIX: begin
        pix_ready = 1'b1;
        if (pix_valid) begin
          state_next = LOAD_ROW0;
        end
      end

      LOAD_ROW0: begin
        host_ready = 1'b1;
        if (host_valid) begin
          word_cnt_next = word_cnt_reg + AW'(1);
          if (last_word) begin
            rows_loaded_next = rows_inc;
            state_next       = RUN;
          end
        end
      end

      RUN: begin
        if (core_done) begin
          state_next = FINISH;
        end else if (next_row && !rows_full) begin
          state_next = REFILL;
        end
      end

      REFILL: begin
        host_ready = 1'b1;
        if (core_done) begin
          // Controller finished while a row was still in flight: abandon it.
          state_next    = FINISH;
          err_next      = 1'b1;
          word_cnt_next = '0;
        end else if (host_valid && last_word) begin
          // A request landing with the final word chains straight into the next refill.
          word_cnt_next    = '0;
          rows_loaded_next = rows_inc;
          if (next_row && (rows_inc < RW'(N_ROWS))) begin
            state_next = REFILL;
          end else begin
            state_next = RUN;
          end
        end else begin
          if (host_valid) begin
            word_cnt_next = word_cnt_reg + AW'(1);
          end
          if (next_row) begin
            err_next = 1'b1;
          end
        end
      end

      FINISH: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign core_reset_next = !((state_next == RUN) || (state_next == REFILL));

  assign in_we        = pix_valid & pix_ready;
  assign w2_we        = word_accept;
  assign w2_addr      = word_cnt_reg;
  assign busy         = (state_reg != IDLE);
  assign done         = (state_reg == FINISH);
  assign err_underrun = err_reg;
  assign core_reset   = core_reset_reg;

  genvar gi;
  generate
    for (gi = 0; gi < DW; gi++) begin : g_data_gate
      assign w2_data[gi] = host_data[gi] & host_ready;
    end
  endgenerate

endmodule

// File: tb/tb_w2_stream_loader.sv
// Directed cycle-by-cycle bench for w2_stream_loader: a vector table for the
// basic load followed by hand-written job sequences.
module tb_w2_stream_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        go;
  logic        pix_valid;
  logic        pix_ready;
  logic        host_valid;
  logic [15:0] host_data;
  logic        host_ready;
  logic        in_we;
  logic        w2_we;
  logic [3:0]  w2_addr;
  logic [15:0] w2_data;
  logic        next_row;
  logic        core_done;
  logic        core_reset;
  logic        busy;
  logic        done;
  logic        err_underrun;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  w2_stream_loader #(
    .DW(16), .ROW_LEN(16), .AW(4), .N_ROWS(10)
  ) dut (
    .clk(clk), .reset(reset), .go(go),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .host_valid(host_valid), .host_data(host_data), .host_ready(host_ready),
    .in_we(in_we), .w2_we(w2_we), .w2_addr(w2_addr), .w2_data(w2_data),
    .next_row(next_row), .core_done(core_done), .core_reset(core_reset),
    .busy(busy), .done(done), .err_underrun(err_underrun)
  );

  typedef struct {
    logic        g;
    logic        pv;
    logic        hv;
    logic [15:0] hd;
    logic        nr;
    logic        cd;
    logic        rs;
    logic [27:0] exp_o;
  } vec_t;

  vec_t tbl[$];

  // Expected output word: {pix_ready, host_ready, in_we, w2_we, w2_addr, w2_data, core_reset, busy, done, err}
  function automatic logic [27:0] eo(input logic pr, input logic hr, input logic iw,
                                     input logic ww, input logic [3:0] a, input logic [15:0] d,
                                     input logic cr, input logic bz, input logic dn, input logic er);
    return {pr, hr, iw, ww, a, d, cr, bz, dn, er};
  endfunction

  function automatic vec_t mkv(input logic g, input logic pv, input logic hv, input logic [15:0] hd,
                               input logic nr, input logic cd, input logic rs, input logic [27:0] e);
    vec_t v;
    v.g = g; v.pv = pv; v.hv = hv; v.hd = hd;
    v.nr = nr; v.cd = cd; v.rs = rs; v.exp_o = e;
    return v;
  endfunction

  function automatic logic [27:0] rst_o(input logic er);
    return eo(0, 0, 0, 0, 4'd0, 16'h0, 1, 0, 0, er);
  endfunction

  function automatic logic [27:0] run_o(input logic er);
    return eo(0, 0, 0, 0, 4'd0, 16'h0, 0, 1, 0, er);
  endfunction

  function automatic logic [27:0] fin_o(input logic er);
    return eo(0, 0, 0, 0, 4'd0, 16'h0, 1, 1, 1, er);
  endfunction

  function automatic logic [27:0] pix_o(input logic pv);
    return eo(1, 0, pv, 0, 4'd0, 16'h0, 1, 1, 0, 0);
  endfunction

  function automatic logic [27:0] row0_o(input logic [3:0] a, input logic [15:0] d);
    return eo(0, 1, 0, 1, a, d, 1, 1, 0, 0);
  endfunction

  function automatic logic [27:0] refill_o(input logic [3:0] a, input logic [15:0] d, input logic er);
    return eo(0, 1, 0, 1, a, d, 0, 1, 0, er);
  endfunction

  // Drive one cycle of inputs at the falling edge and compare outputs 1 ns later.
  task automatic cyc(input logic g, input logic pv, input logic hv, input logic [15:0] hd,
                     input logic nr, input logic cd, input logic rs,
                     input logic [27:0] e, input string tag, input int idx);
    logic [27:0] act;
    @(negedge clk);
    go = g; pix_valid = pv; host_valid = hv; host_data = hd;
    next_row = nr; core_done = cd; reset = rs;
    #1;
    act = {pix_ready, host_ready, in_we, w2_we, w2_addr, w2_data,
           core_reset, busy, done, err_underrun};
    checks++;
    if (act !== e) begin
      failures++;
      $display("FAIL %s[%0d] got=%h expected=%h", tag, idx, act, e);
    end else if (in_we || w2_we || done) begin
      $display("txn %s[%0d] in_we=%0b w2_we=%0b addr=%0d data=%h done=%0b",
               tag, idx, in_we, w2_we, w2_addr, w2_data, done);
    end
  endtask

  task automatic load_row0(input logic [15:0] base, input string tag);
    for (int k = 0; k < 16; k++) begin
      cyc(0, 0, 1, base + 16'(k), 0, 0, 0, row0_o(4'(k), base + 16'(k)), tag, k);
    end
  endtask

  initial begin
    reset = 1'b1; go = 1'b0; pix_valid = 1'b0; host_valid = 1'b0;
    host_data = 16'h0; next_row = 1'b0; core_done = 1'b0;

    // Basic load: reset state, inputs ignored in IDLE, go, pixel, 16 back-to-back words.
    tbl.push_back(mkv(0, 1, 1, 16'hABCD, 1, 1, 1, rst_o(0)));
    tbl.push_back(mkv(0, 1, 1, 16'hABCD, 0, 0, 0, rst_o(0)));
    tbl.push_back(mkv(1, 0, 0, 16'h0000, 0, 0, 0, rst_o(0)));
    tbl.push_back(mkv(0, 1, 0, 16'h0000, 0, 0, 0, pix_o(1)));
    for (int k = 0; k < 16; k++) begin
      tbl.push_back(mkv(0, 0, 1, 16'h0100 + 16'(k), 0, 0, 0, row0_o(4'(k), 16'h0100 + 16'(k))));
    end
    tbl.push_back(mkv(0, 0, 0, 16'h0000, 0, 0, 0, run_o(0)));
    tbl.push_back(mkv(1, 1, 1, 16'h5555, 0, 0, 0, run_o(0)));

    foreach (tbl[i]) begin
      cyc(tbl[i].g, tbl[i].pv, tbl[i].hv, tbl[i].hd, tbl[i].nr, tbl[i].cd, tbl[i].rs,
          tbl[i].exp_o, "basic", i);
    end

    // Full job: rows 2..10 refilled, a surplus request ignored, then completion.
    for (int r = 1; r < 10; r++) begin
      cyc(0, 0, 0, 16'h0, 1, 0, 0, run_o(0), "job_req", r);
      for (int k = 0; k < 16; k++) begin
        cyc(0, 0, 1, 16'h1000 + 16'(r * 16 + k), 0, 0, 0,
            refill_o(4'(k), 16'h1000 + 16'(r * 16 + k), 0), "job_refill", r * 16 + k);
      end
    end
    cyc(0, 0, 0, 16'h0, 1, 0, 0, run_o(0), "job_extra_req", 0);
    cyc(0, 0, 1, 16'h0, 0, 0, 0, run_o(0), "job_extra_ignored", 0);
    cyc(0, 0, 0, 16'h0, 0, 1, 0, run_o(0), "job_core_done", 0);
    cyc(0, 0, 0, 16'h0, 0, 0, 0, fin_o(0), "job_finish", 0);
    cyc(0, 0, 0, 16'h0, 0, 0, 0, rst_o(0), "job_idle", 0);

    // Host stalls during row 0, pixel stall, then an underrun mid-refill.
    cyc(1, 0, 0, 16'h0, 0, 0, 0, rst_o(0), "stall_go", 0);
    cyc(0, 0, 0, 16'h0, 0, 0, 0, pix_o(0), "stall_pix_wait", 0);
    cyc(0, 1, 0, 16'h0, 0, 0, 0, pix_o(1), "stall_pix", 0);
    for (int i = 0; i < 31; i++) begin
      if (i % 2 == 0) begin
        cyc(0, 0, 1, 16'h2000 + 16'((i + 1) / 2), 0, 0, 0,
            row0_o(4'((i + 1) / 2), 16'h2000 + 16'((i + 1) / 2)), "stall_row0", i);
      end else begin
        cyc(0, 0, 0, 16'hDEAD, 0, 0, 0,
            eo(0, 1, 0, 0, 4'((i + 1) / 2), 16'hDEAD, 1, 1, 0, 0), "stall_gap", i);
      end
    end
    cyc(0, 0, 0, 16'h0, 0, 0, 0, run_o(0), "stall_run", 0);
    cyc(0, 0, 0, 16'h0, 1, 0, 0, run_o(0), "under_req", 0);
    for (int k = 0; k < 16; k++) begin
      cyc(0, 0, 1, 16'h3000 + 16'(k), (k == 5), 0, 0,
          refill_o(4'(k), 16'h3000 + 16'(k), (k > 5)), "under_refill", k);
    end
    cyc(0, 0, 0, 16'h0, 0, 0, 0, run_o(1), "under_run", 0);
    cyc(0, 0, 0, 16'h0, 0, 1, 0, run_o(1), "under_core_done", 0);
    cyc(0, 0, 0, 16'h0, 0, 0, 0, fin_o(1), "under_finish", 0);
    cyc(1, 0, 0, 16'h0, 0, 0, 0, rst_o(1), "under_idle_go", 0);
    cyc(0, 1, 0, 16'h0, 0, 0, 0, pix_o(1), "under_cleared", 0);

    // Boundary: request together with the 16th refill word, then reset mid-refill.
    load_row0(16'h4000, "bnd_row0");
    cyc(0, 0, 0, 16'h0, 1, 0, 0, run_o(0), "bnd_req", 0);
    for (int k = 0; k < 16; k++) begin
      cyc(0, 0, 1, 16'h5000 + 16'(k), (k == 15), 0, 0,
          refill_o(4'(k), 16'h5000 + 16'(k), 0), "bnd_refill", k);
    end
    for (int k = 0; k < 7; k++) begin
      cyc(0, 0, 1, 16'h6000 + 16'(k), 0, 0, 0,
          refill_o(4'(k), 16'h6000 + 16'(k), 0), "bnd_chained", k);
    end
    cyc(0, 0, 1, 16'h6007, 0, 0, 1, rst_o(0), "rst_mid_refill", 0);
    cyc(1, 0, 1, 16'h6008, 0, 0, 0, rst_o(0), "rst_go", 0);
    cyc(0, 1, 0, 16'h0, 0, 0, 0, pix_o(1), "rst_pix", 0);
    load_row0(16'h7000, "rst_row0");

    // core_done arriving mid-refill abandons the row and flags an underrun.
    cyc(0, 0, 0, 16'h0, 1, 0, 0, run_o(0), "abandon_req", 0);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 1, 16'h8000 + 16'(k), 0, 0, 0,
          refill_o(4'(k), 16'h8000 + 16'(k), 0), "abandon_refill", k);
    end
    cyc(0, 0, 1, 16'h8003, 0, 1, 0, refill_o(4'd3, 16'h8003, 0), "abandon_core_done", 0);
    cyc(0, 0, 1, 16'h8004, 0, 0, 0, fin_o(1), "abandon_finish", 0);
    cyc(0, 0, 0, 16'h0, 0, 0, 0, rst_o(1), "abandon_idle", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
